// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle for the sequential 32-bit divider
// start/signed_div/annul/opdata1/opdata2 : requester -> divider
// result {rem, quo} / ready (one-cycle pulse) / busy : divider -> requester
interface div_seq_if;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  modport master(output start, signed_div, annul, opdata1, opdata2, input result, ready, busy);
  modport slave(input start, signed_div, annul, opdata1, opdata2, output result, ready, busy);
endinterface

// File: rtl/div_seq.sv
// div_seq: 33-cycle restoring divider (DIV/DIVU) with annul and divide-by-zero shortcut
// clk    : rising-edge clock
// resetn : asynchronous active-low reset
// bus    : div_seq_if.slave (operands/controls in, {rem, quo}, ready, busy out)
module div_seq (
  input logic      clk,
  input logic      resetn,
  div_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [64:0] wr, wr_step;
  logic [31:0] dvs, mag1, mag2;
  logic [32:0] diff;
  logic        neg_q, neg_r, ready_q;
  logic [63:0] result_q;
  always_comb begin
    mag1 = bus.signed_div && bus.opdata1[31] ? -bus.opdata1 : bus.opdata1;
    mag2 = bus.signed_div && bus.opdata2[31] ? -bus.opdata2 : bus.opdata2;
    // trial subtract on the shifted partial remainder; keep it only if non-negative
    diff = wr[63:31] - {1'b0, dvs};
    wr_step = diff[32] ? {wr[63:0], 1'b0} : {diff, wr[30:0], 1'b1};
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start && !bus.annul ? (bus.opdata2 == '0 ? DIVZERO : ON) : IDLE;
      DIVZERO: state_nxt = bus.annul ? IDLE : END;
      ON:      state_nxt = bus.annul ? IDLE : (cnt == 6'd31 ? END : ON);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      wr       <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= state_nxt == END;
      if (state == IDLE && state_nxt != IDLE) begin
        neg_q <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
        neg_r <= bus.signed_div && bus.opdata1[31];
        wr    <= {33'b0, mag1};
        dvs   <= mag2;
        cnt   <= '0;
      end
      if (state == ON) begin
        wr  <= wr_step;
        cnt <= cnt + 6'd1;
      end
      if (state == ON && state_nxt == END)
        result_q <= {neg_r ? -wr_step[63:32] : wr_step[63:32], neg_q ? -wr_step[31:0] : wr_step[31:0]};
      if (state == DIVZERO && state_nxt == END)
        result_q <= '0;
    end
  end
  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = state != IDLE;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: vector table + random scoreboard bench for div_seq
module tb_div_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  div_seq_if bus();
  div_seq dut(.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv, q, r;
    if (b == 0) return 64'h0;
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sbv = b;
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction
  // called at a negedge; returns at the negedge after the ready pulse has ended
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    logic [63:0] held, want;
    held = bus.result;
    bus.start = 1'b1;
    bus.signed_div = sd;
    bus.opdata1 = a;
    bus.opdata2 = b;
    sb.push_back(exp);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (cyc == 1) chk("result_held", bus.result, held);
    end while (!bus.ready && cyc < 64);
    chk("latency", 64'(cyc), b == 0 ? 64'd2 : 64'd33);
    want = sb.pop_front();
    chk("result", bus.result, want);
    @(negedge clk);
    chk("ready_pulse", {62'b0, bus.ready, bus.busy}, 64'h0);
  endtask
  initial begin
    logic [63:0] held;
    logic        saw_ready;
    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC};
    vecs[3] = '{1'b1, 32'd5,          32'd0,        64'h0};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[5] = '{1'b1, 32'd100,        32'hFFFFFFF9, 64'h00000002_FFFFFFF2};
    vecs[6] = '{1'b0, 32'd0,          32'd5,        64'h0};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
    vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E};
    vecs[9] = '{1'b0, 32'd7,          32'd100,      64'h00000007_00000000};
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    #1;
    chk("reset_state", {bus.result, 61'b0, bus.ready, bus.busy}, 128'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) run_op(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp);
    for (int i = 0; i < 8; i++) begin
      logic sd;
      logic [31:0] a, b;
      sd = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(sd, a, b, model(sd, a, b));
    end
    // annul with start in IDLE captures nothing
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    @(negedge clk);
    chk("annul_idle_busy", {63'b0, bus.busy}, 64'h0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    // annul at step 10 of a running DIV 100/7
    held = bus.result;
    saw_ready = 1'b0;
    bus.start = 1'b1;
    bus.signed_div = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      saw_ready |= bus.ready;
    end
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    saw_ready |= bus.ready;
    chk("annul_on_state", {62'b0, bus.busy, saw_ready}, 64'h0);
    chk("annul_on_result", bus.result, held);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw_ready |= bus.ready;
    end
    chk("annul_no_late_ready", {63'b0, saw_ready}, 64'h0);
    run_op(1'b1, 32'd100, 32'd7, 64'h00000002_0000000E);
    // annul during DIVZERO
    held = bus.result;
    bus.start = 1'b1;
    bus.opdata1 = 32'd5;
    bus.opdata2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.annul = 1'b1;
    chk("divzero_busy", {63'b0, bus.busy}, 64'h1);
    @(negedge clk);
    bus.annul = 1'b0;
    chk("annul_divzero", {bus.result, 62'b0, bus.ready, bus.busy}, {held, 64'h0});
    // asynchronous reset at step 20
    saw_ready = 1'b0;
    bus.start = 1'b1;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      saw_ready |= bus.ready;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset", {bus.result, 62'b0, bus.ready, bus.busy}, 128'h0);
    @(negedge clk);
    @(negedge clk);
    saw_ready |= bus.ready;
    resetn = 1'b1;
    chk("reset_no_ready", {63'b0, saw_ready}, 64'h0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
